// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and width helpers for the vector processing element
//
// Contents:
//   pe_state_e  - accumulator FSM state (IDLE: no open vector, ACCUM: vector open)
//   prod_width  - width of one signed lane product
//   sum_width   - width of the signed sum of all lane products
package pe_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pe_state_e;

    function automatic int prod_width(input int input_width);
        return 2 * input_width;
    endfunction

    // Each doubling of the lane count can add one bit of growth to the sum.
    function automatic int sum_width(input int input_width, input int lanes);
        return prod_width(input_width) + $clog2(lanes);
    endfunction

endpackage

// File: rtl/pe_weight_mem.sv
// rtl/pe_weight_mem.sv - register-file weight memory, one combinational read, one write port
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears every entry)
//   wr_en     - write wr_data into entry wr_addr at the next rising edge
//   wr_addr   - write address; out-of-range writes are dropped
//   wr_data   - LANES raw INPUT_WIDTH lanes
//   rd_addr   - read address; out-of-range reads return 0
//   rd_data   - entry contents, combinational (a same-cycle write is not yet visible)
module pe_weight_mem #(
    parameter int LANES       = 4,
    parameter int INPUT_WIDTH = 16,
    parameter int MEM_DEPTH   = 16,
    parameter int ADDR_WIDTH  = $clog2(MEM_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [LANES*INPUT_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [LANES*INPUT_WIDTH-1:0] rd_data
);

    logic [LANES*INPUT_WIDTH-1:0] mem [MEM_DEPTH];

    logic wr_in_range;
    logic rd_in_range;

    // Only matters when MEM_DEPTH is not a power of two.
    assign wr_in_range = (32'(wr_addr) < MEM_DEPTH);
    assign rd_in_range = (32'(rd_addr) < MEM_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = rd_in_range ? mem[rd_addr] : '0;

endmodule

// File: rtl/vector_pe.sv
// rtl/vector_pe.sv - streamed multi-lane signed dot-product processing element
//
// Each accepted beat multiplies LANES signed activations by LANES signed weights
// (direct or from the local weight memory) and sums the products; sums accumulate
// across beats until in_last, then one result is offered on out_valid/out_ready.
// Pipeline: P1 (products) -> P2 (lane sum) -> accumulator FSM / result register.
//
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   in_valid/in_ready                 - beat handshake (in_ready = global advance enable)
//   in_data, in_weight                - packed lanes, lane i at [i*INPUT_WIDTH +: INPUT_WIDTH]
//   in_use_stored, in_addr            - take weights from memory entry in_addr instead
//   in_last                           - final beat of the vector
//   wr_en, wr_addr, wr_data           - weight-memory write (proceeds during stalls)
//   out_valid/out_ready, out_result   - one signed result per vector
//   out_overflow                      - saturation seen in this vector
//   busy                              - vector open or a pipeline stage valid
//
// Build option: PE_SATURATE_EN clamps every accumulator update to the signed
// OUTPUT_WIDTH range and drives out_overflow; without it arithmetic wraps and
// out_overflow is tied 0.
module vector_pe
    import pe_pkg::*;
#(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 40,
    parameter int LANES        = 4,
    parameter int MEM_DEPTH    = 16,
    parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*INPUT_WIDTH-1:0]   in_data,
    input  logic [LANES*INPUT_WIDTH-1:0]   in_weight,
    input  logic                           in_use_stored,
    input  logic [ADDR_WIDTH-1:0]          in_addr,
    input  logic                           in_last,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [LANES*INPUT_WIDTH-1:0]   wr_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [OUTPUT_WIDTH-1:0] out_result,
    output logic                           out_overflow,
    output logic                           busy
);

    localparam int VEC_W  = LANES * INPUT_WIDTH;
    localparam int PROD_W = prod_width(INPUT_WIDTH);
    localparam int SUM_W  = sum_width(INPUT_WIDTH, LANES);

    logic                           en;
    logic [VEC_W-1:0]               mem_rd_data;
    logic [VEC_W-1:0]               weight_row;
    logic signed [PROD_W-1:0]       prod_next [LANES];

    logic                           p1_valid;
    logic                           p1_last;
    logic signed [PROD_W-1:0]       p1_prod [LANES];

    logic signed [SUM_W-1:0]        tree_sum;
    logic                           p2_valid;
    logic                           p2_last;
    logic signed [SUM_W-1:0]        p2_sum;

    pe_state_e                      state;
    logic signed [OUTPUT_WIDTH-1:0] acc;
    logic signed [OUTPUT_WIDTH-1:0] next_val;

    // A held, unaccepted result freezes the whole pipeline and the FSM.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign busy     = (state == ACCUM) || p1_valid || p2_valid;

    pe_weight_mem #(
        .LANES       (LANES),
        .INPUT_WIDTH (INPUT_WIDTH),
        .MEM_DEPTH   (MEM_DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_weight_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (in_addr),
        .rd_data (mem_rd_data)
    );

    assign weight_row = in_use_stored ? mem_rd_data : in_weight;

    // Lanes are sign-extended to product width before multiplying.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_next[i] = PROD_W'(signed'(in_data[i*INPUT_WIDTH +: INPUT_WIDTH]))
                         * PROD_W'(signed'(weight_row[i*INPUT_WIDTH +: INPUT_WIDTH]));
        end
    end

    // SUM_W has enough headroom that this reduction never overflows.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + SUM_W'(p1_prod[i]);
        end
    end

`ifdef PE_SATURATE_EN
    // One extra bit over the wider of acc and the lane sum keeps the raw
    // total exact, so the clamp decision never sees a wrapped value.
    localparam int EXT_W = ((OUTPUT_WIDTH > SUM_W) ? OUTPUT_WIDTH : SUM_W) + 1;

    logic signed [EXT_W-1:0] total;
    logic                    sat_pos;
    logic                    sat_neg;
    logic                    vec_ov;
    logic                    ov_acc;

    always_comb begin
        total   = ((state == ACCUM) ? EXT_W'(acc) : '0) + EXT_W'(p2_sum);
        // Bits above the result's sign bit must all match the sign to fit.
        sat_pos = !total[EXT_W-1] && (|total[EXT_W-2:OUTPUT_WIDTH-1]);
        sat_neg = total[EXT_W-1] && !(&total[EXT_W-2:OUTPUT_WIDTH-1]);
        if (sat_pos) begin
            next_val = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        end else if (sat_neg) begin
            next_val = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
        end else begin
            next_val = total[OUTPUT_WIDTH-1:0];
        end
        // Sticky within a vector; a fresh vector starts clean.
        vec_ov = (sat_pos || sat_neg) || ((state == ACCUM) && ov_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ov_acc       <= 1'b0;
            out_overflow <= 1'b0;
        end else if (en && p2_valid) begin
            if (p2_last) begin
                out_overflow <= vec_ov;
            end else begin
                ov_acc <= vec_ov;
            end
        end
    end
`else
    always_comb begin
        next_val = ((state == ACCUM) ? acc : '0) + OUTPUT_WIDTH'(p2_sum);
    end

    assign out_overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid <= 1'b0;
            p1_last  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                p1_prod[i] <= '0;
            end
            p2_valid   <= 1'b0;
            p2_last    <= 1'b0;
            p2_sum     <= '0;
            state      <= IDLE;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (en) begin
            p1_valid <= in_valid;
            p1_last  <= in_last;
            for (int i = 0; i < LANES; i++) begin
                p1_prod[i] <= prod_next[i];
            end
            p2_valid <= p1_valid;
            p2_last  <= p1_last;
            p2_sum   <= tree_sum;

            // en implies any held result is being taken now, so out_valid
            // simply follows whether a new result loads this cycle.
            out_valid <= p2_valid && p2_last;

            if (p2_valid) begin
                if (p2_last) begin
                    out_result <= next_val;
                    state      <= IDLE;
                end else begin
                    acc   <= next_val;
                    state <= ACCUM;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_pe.sv
// tb/tb_vector_pe.sv - directed self-checking bench for vector_pe (LANES=4, INPUT_WIDTH=16, OUTPUT_WIDTH=32)
module tb_vector_pe;

    localparam int IW = 16;
    localparam int OW = 32;
    localparam int LN = 4;
    localparam int MD = 16;
    localparam int AW = 4;

`ifdef PE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [63:0]    in_data;
    logic [63:0]    in_weight;
    logic           in_use_stored;
    logic [AW-1:0]  in_addr;
    logic           in_last;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [63:0]    wr_data;
    logic           out_valid;
    logic           out_ready;
    logic [OW-1:0]  out_result;
    logic           out_overflow;
    logic           busy;

    always #5 clk = ~clk;

    vector_pe #(
        .INPUT_WIDTH  (IW),
        .OUTPUT_WIDTH (OW),
        .LANES        (LN),
        .MEM_DEPTH    (MD),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_weight     (in_weight),
        .in_use_stored (in_use_stored),
        .in_addr       (in_addr),
        .in_last       (in_last),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .busy          (busy)
    );

    typedef struct {
        logic [63:0] d;
        logic [63:0] w;
        logic [31:0] res;
        logic        ov;
    } vec_t;

    vec_t        vt [8];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] rq [$];
    logic        oq [$];

    // Record every completed output handshake, sampled mid-cycle.
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            rq.push_back(out_result);
            oq.push_back(out_overflow);
        end
    end

    function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic beat(input logic [63:0] d, input logic [63:0] w, input logic st,
                        input logic [AW-1:0] a, input logic l);
        int t;
        t             = 0;
        in_data       = d;
        in_weight     = w;
        in_use_stored = st;
        in_addr       = a;
        in_last       = l;
        in_valid      = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) timeout_fail("beat accept");
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [31:0] er, input logic eov);
        int t;
        t = 0;
        while (rq.size() == 0 && t < 40) begin
            @(negedge clk);
            #3;
            t++;
        end
        if (rq.size() == 0) begin
            timeout_fail(name);
        end else begin
            logic [31:0] r;
            logic        o;
            r = rq.pop_front();
            o = oq.pop_front();
            check({name, " result"}, r, er);
            check({name, " overflow"}, {31'b0, o}, {31'b0, eov});
        end
    endtask

    initial begin
        vt[0] = '{pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 32'd70, 1'b0};
        vt[1] = '{pack4(-1, 2, -3, 4), pack4(5, -6, 7, -8), 32'hFFFF_FFBA, 1'b0};
        vt[2] = '{pack4(0, 0, 0, 0), pack4(123, -5, 7, 9), 32'd0, 1'b0};
        vt[3] = '{pack4(32767, 32767, 32767, 32767), pack4(32767, 32767, 32767, 32767),
                  SAT ? 32'h7FFF_FFFF : 32'hFFFC_0004, SAT};
        vt[4] = '{pack4(-32768, -32768, -32768, -32768), pack4(32767, 32767, 32767, 32767),
                  SAT ? 32'h8000_0000 : 32'h0002_0000, SAT};
        vt[5] = '{pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768),
                  SAT ? 32'h7FFF_FFFF : 32'h0000_0000, SAT};
        vt[6] = '{pack4(100, 200, 300, 400), pack4(-1, -1, -1, -1), 32'hFFFF_FC18, 1'b0};
        vt[7] = '{pack4(3, -4, 5, -6), pack4(-7, 8, 9, 10), 32'hFFFF_FFBC, 1'b0};

        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        in_weight     = '0;
        in_use_stored = 1'b0;
        in_addr       = '0;
        in_last       = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        out_ready     = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset out_result", out_result, 32'd0);
        check("reset out_overflow", {31'b0, out_overflow}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);

        // Latency: last beat at edge k -> out_valid only after edge k+2
        beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0, '0, 1'b1);
        check("latency k", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency k+1", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency k+2 valid", {31'b0, out_valid}, 32'd1);
        check("latency k+2 result", out_result, 32'd70);
        expect_result("latency", 32'd70, 1'b0);

        // Single-beat table
        for (int i = 0; i < 8; i++) begin
            beat(vt[i].d, vt[i].w, 1'b0, '0, 1'b1);
            expect_result($sformatf("table[%0d]", i), vt[i].res, vt[i].ov);
        end

        // Back-to-back vectors with no gap
        beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b0, '0, 1'b1);
        beat(pack4(2, 0, 0, 0), pack4(3, 0, 0, 0), 1'b0, '0, 1'b1);
        expect_result("b2b first", 32'd4, 1'b0);
        expect_result("b2b second", 32'd6, 1'b0);

        // Stored weights: entry 3 = {-1,-1,-1,-1}, three beats of {2,2,2,2}
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_data = pack4(-1, -1, -1, -1);
        @(negedge clk);
        wr_en = 1'b0;
        beat(pack4(2, 2, 2, 2), '0, 1'b1, 4'd3, 1'b0);
        beat(pack4(2, 2, 2, 2), '0, 1'b1, 4'd3, 1'b0);
        beat(pack4(2, 2, 2, 2), '0, 1'b1, 4'd3, 1'b1);
        expect_result("stored", 32'hFFFF_FFE8, 1'b0);

        // Same-cycle write and read of entry 5 sees old data; next beat sees new
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = pack4(1, 1, 1, 1);
        beat(pack4(1, 1, 1, 1), '0, 1'b1, 4'd5, 1'b1);
        wr_en = 1'b0;
        beat(pack4(1, 1, 1, 1), '0, 1'b1, 4'd5, 1'b1);
        expect_result("wr/rd collision old", 32'd0, 1'b0);
        expect_result("wr/rd after write", 32'd4, 1'b0);

        // Sticky overflow within a two-beat vector
        beat(pack4(32767, 32767, 32767, 32767), pack4(32767, 32767, 32767, 32767), 1'b0, '0, 1'b0);
        beat(pack4(-1, 0, 0, 0), pack4(1, 0, 0, 0), 1'b0, '0, 1'b1);
        expect_result("sticky", SAT ? 32'h7FFF_FFFE : 32'hFFFC_0003, SAT);

        // Backpressure: result held for 5 cycles, pipeline frozen
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                beat(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 1'b0, '0, 1'b1);
                beat(pack4(1, 2, 3, 4), pack4(2, 2, 2, 2), 1'b0, '0, 1'b1);
                beat(pack4(1, 2, 3, 4), pack4(3, 3, 3, 3), 1'b0, '0, 1'b1);
            end
            begin
                int t;
                t = 0;
                while (!out_valid && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                if (!out_valid) timeout_fail("stall out_valid");
                for (int i = 0; i < 5; i++) begin
                    check($sformatf("stall in_ready %0d", i), {31'b0, in_ready}, 32'd0);
                    check($sformatf("stall hold %0d", i), out_result, 32'd10);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        expect_result("stall A", 32'd10, 1'b0);
        expect_result("stall B", 32'd20, 1'b0);
        expect_result("stall C", 32'd30, 1'b0);

        // Reset mid-vector discards the open vector
        rq.delete();
        oq.delete();
        beat(pack4(100, 100, 100, 100), pack4(5, 5, 5, 5), 1'b0, '0, 1'b0);
        beat(pack4(100, 100, 100, 100), pack4(5, 5, 5, 5), 1'b0, '0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", {31'b0, busy}, 32'd0);
        check("midrst out_valid", {31'b0, out_valid}, 32'd0);
        beat(pack4(1, 0, 0, 0), pack4(9, 0, 0, 0), 1'b0, '0, 1'b1);
        repeat (10) @(negedge clk);
        check("midrst result count", rq.size(), 32'd1);
        expect_result("midrst", 32'd9, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vector_pe.md
# vector_pe

Multi-lane successor to the single-lane processing element. Computes a streamed dot product: each accepted beat multiplies LANES signed activations by LANES signed weights and sums the products. Weights come from the beat or from a local weight memory. Products accumulate over a multi-beat vector, terminated by `in_last`, and the block returns one result per vector over a valid/ready output. It sits between the activation/weight feeders and the result collector, and is the building block for PE rows.

## Interface
- `INPUT_WIDTH`, 16: signed width of each activation/weight lane.
- `OUTPUT_WIDTH`, 40: signed accumulator/result width; must be at least 2*INPUT_WIDTH+$clog2(LANES).
- `LANES`, 4: parallel multipliers per beat; must be at least 1.
- `MEM_DEPTH`, 16: weight-memory entries, each LANES*INPUT_WIDTH bits.
- `ADDR_WIDTH`, $clog2(MEM_DEPTH): weight-memory address width.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: beat present.
- `in_ready` output 1: block accepts a beat this cycle.
- `in_data` input LANES*INPUT_WIDTH: activations; lane i is bits [i*INPUT_WIDTH +: INPUT_WIDTH].
- `in_weight` input LANES*INPUT_WIDTH: direct weights, same lane packing as `in_data`.
- `in_use_stored` input 1: 1 selects weight-memory entry `in_addr` instead of `in_weight`.
- `in_addr` input ADDR_WIDTH: weight-memory read address.
- `in_last` input 1: final beat of the current vector.
- `wr_en` input 1: write `wr_data` into entry `wr_addr`.
- `wr_addr` input ADDR_WIDTH: weight-memory write address.
- `wr_data` input LANES*INPUT_WIDTH: weights to store.
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer takes the result.
- `out_result` output OUTPUT_WIDTH: signed dot-product result.
- `out_overflow` output 1: saturation occurred in this vector. Only driven with `PE_SATURATE_EN`; constant 0 otherwise.
- `busy` output 1: a vector is open or a pipeline stage is valid.

## Operation
- Beat accepted when `in_valid && in_ready`.
- Global advance enable `en = !(out_valid && !out_ready)`.
  - `in_ready = en` (combinational).
  - When `en` is 0, all pipeline stages and the FSM freeze.
- P1 stage (registered):
  - Weight select: memory entries are read combinationally.
  - LANES signed products, each 2*INPUT_WIDTH bits.
  - `last` flag and valid bit.
- P2 stage:
  - Sum the products as a signed adder tree.
  - Sign-extend the sum to OUTPUT_WIDTH.
- FSM states: IDLE (no open vector) and ACCUM (vector open).
  - IDLE, P2 beat with `last` = 0: acc <= sum, go to ACCUM.
  - IDLE, P2 beat with `last` = 1: out_result <= sum, out_valid <= 1, stay IDLE (single-beat vector).
  - ACCUM, P2 beat with `last` = 0: acc <= acc + sum.
  - ACCUM, P2 beat with `last` = 1: out_result <= acc + sum, out_valid <= 1, go to IDLE.
- `out_valid` clears when `out_ready` is high, unless a new result loads in the same cycle; then it stays 1 with the new value.
- Arithmetic without the macro: two's-complement, wraps modulo 2^OUTPUT_WIDTH.
- Weight memory:
  - Stores raw INPUT_WIDTH lanes, with no sign extension in storage.
  - A write is visible to reads from the next cycle.
  - Same-cycle write and read of the same address returns the old data.
  - Writes are independent of `en`, so they proceed during a stall.
- Out-of-range addresses (MEM_DEPTH not a power of two) read 0 and drop writes.

## Timing
- Reset values:
  - `out_valid` 0, `out_result` 0, `out_overflow` 0, `busy` 0.
  - `in_ready` 1 on the first cycle after reset.
  - FSM in IDLE, both pipeline valids 0, acc 0, all memory entries 0.
- Latency: a last beat accepted at edge k gives `out_valid` = 1 after edge k+2. Throughput is one beat per cycle.
- Back-to-back vectors with no gap:
  - The next vector's first beat is accepted the cycle after the previous last beat.
  - Its first P2 beat loads acc rather than adding to it.
- Reset mid-vector or mid-stall: the open vector and any pending result are discarded; no partial output appears.
- `in_valid` low during ACCUM: the vector stays open indefinitely.

## Configuration
- `PE_SATURATE_EN` defined:
  - Each acc update clamps to the signed range [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
  - `out_overflow` is sticky per vector and loads together with `out_result`.
- Undefined: wrap-around arithmetic; `out_overflow` tied 0.

## Structure
- Package `pe_pkg`:
  - FSM state enum (IDLE, ACCUM).
  - Localparam function giving product width and tree-sum width from INPUT_WIDTH and LANES.
- Sub-module `pe_weight_mem`: register-file weight memory.
  - Parametrised by LANES, INPUT_WIDTH, MEM_DEPTH.
  - One combinational read port, one write port, synchronous reset clear.

## Test plan
All scenarios use LANES=4, INPUT_WIDTH=16.
- Single beat: data {1,2,3,4}, weight {5,6,7,8}, `in_last`=1 at edge k -> `out_valid` after edge k+2, `out_result`=70.
- Stored weights: write entry 3 = {-1,-1,-1,-1}; then 3 beats of data {2,2,2,2} with `in_use_stored`=1, `in_addr`=3 -> `out_result`=-24.
- Back-to-back vectors: {1,1,1,1}·{1,1,1,1} last, immediately followed by {2,0,0,0}·{3,0,0,0} last -> results 4 then 6.
- Backpressure: hold `out_ready`=0 for 5 cycles with a result pending -> `in_ready`=0, pipeline frozen; results delivered in order and unchanged.
- Saturation at OUTPUT_WIDTH=32: data 0x7FFF, weight 0x7FFF on all lanes, one beat -> with `PE_SATURATE_EN`, result 0x7FFFFFFF and `out_overflow`=1; without it, result 0xFFFC0004.
- Reset mid-vector: 2 beats open, pulse `rst`, then a single beat {1,0,0,0}·{9,0,0,0} -> `out_result`=9, and no earlier result ever appears.
